// File: rtl/xy_shape_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : xy_shape_stepper
//  Purpose  : Table-driven X/Y shape tracer. Walks the segment list of the
//             selected shape from an external synchronous ROM and uses DDA
//             interpolation so both axes finish every segment together.
//  Revision : 1.0  initial release
// ============================================================================
module xy_shape_stepper #(
  parameter int NUM_SHAPES = 4,
  parameter int SEL_W      = 2,
  parameter int SEG_AW     = 6,
  parameter int STEP_W     = 12,
  parameter int PERIOD_W   = 16
) (
  input  logic                     sysclk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [SEL_W-1:0]         shape_sel,
  input  logic [PERIOD_W-1:0]      period,
  output logic [SEL_W+SEG_AW-1:0]  rom_addr,
  input  logic signed [STEP_W-1:0] rom_dx,
  input  logic signed [STEP_W-1:0] rom_dy,
  input  logic                     rom_last,
  output logic                     pulse_x,
  output logic                     pulse_y,
  output logic                     dir_x,
  output logic                     dir_y,
  output logic                     busy,
  output logic                     shape_done,
  output logic [SEL_W-1:0]         active_shape
);

  // The shape select must address exactly NUM_SHAPES shapes.
  if ((1 << SEL_W) != NUM_SHAPES) begin : g_sel_width_check
    $error("SEL_W must equal log2(NUM_SHAPES)");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    active_shape_q, active_shape_d;
  logic [SEG_AW-1:0]   seg_idx_q, seg_idx_d;
  logic [STEP_W-1:0]   major_q, major_d;
  logic [STEP_W-1:0]   minor_q, minor_d;
  logic [STEP_W-1:0]   remaining_q, remaining_d;
  logic [STEP_W:0]     acc_q, acc_d;
  logic [PERIOD_W-1:0] tick_q, tick_d;
  logic [PERIOD_W-1:0] reload_q, reload_d;
  logic                x_major_q, x_major_d;
  logic                last_q, last_d;
  logic                dir_x_q, dir_x_d;
  logic                dir_y_q, dir_y_d;
  logic                pulse_x_q, pulse_x_d;
  logic                pulse_y_q, pulse_y_d;
  logic                done_q, done_d;

  logic [STEP_W-1:0]   ax, ay, ld_major, ld_minor;
  logic [PERIOD_W-1:0] eff_m1;
  logic [STEP_W:0]     acc_sum;
  logic                minor_hit;
  logic                seg_end, seg_end_last;

  // Magnitude with the most negative code clamped to the largest positive one.
  function automatic logic [STEP_W-1:0] abs_sat(input logic signed [STEP_W-1:0] v);
    if (!v[STEP_W-1])
      return v;
    else if (v == {1'b1, {(STEP_W-1){1'b0}}})
      return {1'b0, {(STEP_W-1){1'b1}}};
    else
      return -v;
  endfunction

  // Segment decode, effective period and DDA accumulator arithmetic.
  always_comb begin
    ax        = abs_sat(rom_dx);
    ay        = abs_sat(rom_dy);
    ld_major  = (ax >= ay) ? ax : ay;
    ld_minor  = (ax >= ay) ? ay : ax;
    eff_m1    = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
    acc_sum   = acc_q + {1'b0, minor_q};
    minor_hit = (acc_sum >= {1'b0, major_q});
  end

  // Next-state logic: sequencing, tick timing, pulse generation, segment advance.
  always_comb begin
    state_d        = state_q;
    active_shape_d = active_shape_q;
    seg_idx_d      = seg_idx_q;
    major_d        = major_q;
    minor_d        = minor_q;
    remaining_d    = remaining_q;
    acc_d          = acc_q;
    tick_d         = tick_q;
    reload_d       = reload_q;
    x_major_d      = x_major_q;
    last_d         = last_q;
    dir_x_d        = dir_x_q;
    dir_y_d        = dir_y_q;
    pulse_x_d      = 1'b0;
    pulse_y_d      = 1'b0;
    done_d         = 1'b0;
    seg_end        = 1'b0;
    seg_end_last   = 1'b0;

    if (state_q != IDLE && !enable) begin
      // Stop request: drop any in-flight tick, keep direction lines stable.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_d        = FETCH;
            active_shape_d = shape_sel;
            seg_idx_d      = '0;
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          dir_x_d     = rom_dx[STEP_W-1];
          dir_y_d     = rom_dy[STEP_W-1];
          major_d     = ld_major;
          minor_d     = ld_minor;
          x_major_d   = (ax >= ay);
          acc_d       = {1'b0, ld_major} >> 1;
          remaining_d = ld_major;
          tick_d      = eff_m1;
          reload_d    = eff_m1;
          last_d      = rom_last;
          if (ld_major == '0) begin
            seg_end      = 1'b1;
            seg_end_last = rom_last;
            state_d      = FETCH;
          end else begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick_q != '0) begin
            tick_d = tick_q - PERIOD_W'(1);
          end else begin
            tick_d      = reload_q;
            pulse_x_d   = x_major_q ? 1'b1 : minor_hit;
            pulse_y_d   = x_major_q ? minor_hit : 1'b1;
            acc_d       = minor_hit ? (acc_sum - {1'b0, major_q}) : acc_sum;
            remaining_d = remaining_q - STEP_W'(1);
            if (remaining_q == STEP_W'(1)) begin
              seg_end      = 1'b1;
              seg_end_last = last_q;
              state_d      = FETCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Loop boundary is the only place a new shape selection is accepted.
    if (seg_end) begin
      if (seg_end_last || seg_idx_q == {SEG_AW{1'b1}}) begin
        done_d         = 1'b1;
        seg_idx_d      = '0;
        active_shape_d = shape_sel;
      end else begin
        seg_idx_d = seg_idx_q + SEG_AW'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q        <= IDLE;
      active_shape_q <= '0;
      seg_idx_q      <= '0;
      major_q        <= '0;
      minor_q        <= '0;
      remaining_q    <= '0;
      acc_q          <= '0;
      tick_q         <= '0;
      reload_q       <= '0;
      x_major_q      <= 1'b0;
      last_q         <= 1'b0;
      dir_x_q        <= 1'b0;
      dir_y_q        <= 1'b0;
      pulse_x_q      <= 1'b0;
      pulse_y_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_shape_q <= active_shape_d;
      seg_idx_q      <= seg_idx_d;
      major_q        <= major_d;
      minor_q        <= minor_d;
      remaining_q    <= remaining_d;
      acc_q          <= acc_d;
      tick_q         <= tick_d;
      reload_q       <= reload_d;
      x_major_q      <= x_major_d;
      last_q         <= last_d;
      dir_x_q        <= dir_x_d;
      dir_y_q        <= dir_y_d;
      pulse_x_q      <= pulse_x_d;
      pulse_y_q      <= pulse_y_d;
      done_q         <= done_d;
    end
  end

  assign rom_addr     = {active_shape_q, seg_idx_q};
  assign pulse_x      = pulse_x_q;
  assign pulse_y      = pulse_y_q;
  assign dir_x        = dir_x_q;
  assign dir_y        = dir_y_q;
  assign busy         = (state_q != IDLE);
  assign shape_done   = done_q;
  assign active_shape = active_shape_q;

endmodule
`default_nettype wire

// File: tb/tb_xy_shape_stepper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xy_shape_stepper
//  Purpose  : Randomised self-checking bench for xy_shape_stepper. A timeline
//             model derives every expected pulse from the segment table with
//             closed-form DDA arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_xy_shape_stepper;
  localparam int MAXT = 8192;

  logic               sysclk = 1'b0;
  logic               reset, enable;
  logic [1:0]         shape_sel;
  logic [15:0]        period;
  logic [7:0]         rom_addr;
  logic signed [11:0] rom_dx, rom_dy;
  logic               rom_last;
  logic               pulse_x, pulse_y, dir_x, dir_y, busy, shape_done;
  logic [1:0]         active_shape;

  xy_shape_stepper dut (
    .sysclk(sysclk), .reset(reset), .enable(enable), .shape_sel(shape_sel),
    .period(period), .rom_addr(rom_addr), .rom_dx(rom_dx), .rom_dy(rom_dy),
    .rom_last(rom_last), .pulse_x(pulse_x), .pulse_y(pulse_y), .dir_x(dir_x),
    .dir_y(dir_y), .busy(busy), .shape_done(shape_done), .active_shape(active_shape)
  );

  always #5 sysclk = ~sysclk;

  // Segment table and synchronous ROM (data valid the cycle after the address).
  logic signed [11:0] mem_dx [0:255];
  logic signed [11:0] mem_dy [0:255];
  logic               mem_last [0:255];

  always @(posedge sysclk) begin
    rom_dx   <= mem_dx[rom_addr];
    rom_dy   <= mem_dy[rom_addr];
    rom_last <= mem_last[rom_addr];
  end

  int checks = 0;
  int errors = 0;
  int cnt_x, cnt_y, cnt_done;

  // Input schedules and expected per-cycle outputs.
  int sel_at [0:MAXT-1];
  int per_at [0:MAXT-1];
  bit e_px [0:MAXT-1];
  bit e_py [0:MAXT-1];
  bit e_done [0:MAXT-1];
  bit e_busy [0:MAXT-1];
  int e_addr [0:MAXT-1];
  bit e_dx [0:MAXT-1];
  bit e_dy [0:MAXT-1];

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle=%0d actual=%0h required=%0h", tag, cyc, got, exp);
    end
  endtask

  // Timeline model: cycle 0 is the IDLE cycle where enable rises; enable stays
  // high through cycle E-1. Each segment spends one FETCH and one LOAD cycle,
  // then major*P RUN cycles; tick k becomes visible at FETCH+2+k*P.
  task automatic build_model(input int E);
    int t, shp, seg;
    for (int i = 0; i <= E + 2; i++) begin
      e_px[i] = 0; e_py[i] = 0; e_done[i] = 0; e_busy[i] = (i >= 1 && i <= E);
      e_addr[i] = 0; e_dx[i] = 0; e_dy[i] = 0;
    end
    t = 1; shp = sel_at[0]; seg = 0;
    while (t <= E) begin
      int a, dx, dy, ax, ay, p, maj, mnr, h, tend;
      bit xm;
      a  = shp * 64 + seg;
      dx = mem_dx[a]; dy = mem_dy[a];
      ax = (dx < 0) ? -dx : dx; if (ax > 2047) ax = 2047;
      ay = (dy < 0) ? -dy : dy; if (ay > 2047) ay = 2047;
      p  = per_at[t + 1]; if (p < 2) p = 2;
      xm  = (ax >= ay);
      maj = xm ? ax : ay;
      mnr = xm ? ay : ax;
      h   = maj / 2;
      tend = t + 2 + maj * p;
      for (int u = t; u < tend && u <= E; u++) e_addr[u] = a;
      for (int k = 1; k <= maj; k++) begin
        int tv;
        bit mhit;
        tv = t + 2 + k * p;
        if (tv > E) break;
        mhit = ((h + k * mnr) / maj) > ((h + (k - 1) * mnr) / maj);
        if (xm || mhit) begin e_px[tv] = 1; e_dx[tv] = (dx < 0); end
        if (!xm || mhit) begin e_py[tv] = 1; e_dy[tv] = (dy < 0); end
      end
      if (tend <= E) begin
        if (mem_last[a] || seg == 63) begin
          e_done[tend] = 1; seg = 0; shp = sel_at[tend - 1];
        end else begin
          seg++;
        end
      end
      t = tend;
    end
    e_addr[E + 1] = e_addr[E];
    e_addr[E + 2] = e_addr[E];
  endtask

  task automatic sched(input int E, input int s0, input int p0, input bit vary);
    int s, p;
    s = s0; p = p0;
    for (int c = 0; c <= E + 2; c++) begin
      if (vary && $urandom_range(0, 99) < 2) s = $urandom_range(0, 3);
      if (vary && $urandom_range(0, 99) < 2) p = $urandom_range(0, 4);
      sel_at[c] = s; per_at[c] = p;
    end
  endtask

  task automatic do_run(input int E);
    build_model(E);
    cnt_x = 0; cnt_y = 0; cnt_done = 0;
    for (int c = 0; c <= E + 2; c++) begin
      @(posedge sysclk); #1;
      enable    = (c < E);
      shape_sel = 2'(sel_at[c]);
      period    = 16'(per_at[c]);
      @(negedge sysclk);
      if (c >= 1) begin
        chk("pulse_x", c, 32'(pulse_x), 32'(e_px[c]));
        chk("pulse_y", c, 32'(pulse_y), 32'(e_py[c]));
        chk("shape_done", c, 32'(shape_done), 32'(e_done[c]));
        chk("busy", c, 32'(busy), 32'(e_busy[c]));
        chk("rom_addr", c, 32'(rom_addr), e_addr[c]);
        if (e_px[c]) chk("dir_x", c, 32'(dir_x), 32'(e_dx[c]));
        if (e_py[c]) chk("dir_y", c, 32'(dir_y), 32'(e_dy[c]));
        cnt_x += int'(pulse_x); cnt_y += int'(pulse_y); cnt_done += int'(shape_done);
      end
    end
  endtask

  task automatic fill_random();
    int l2;
    l2 = $urandom_range(1, 5);
    for (int s = 0; s < 64; s++) begin
      mem_dx[128 + s]   = 12'(int'($urandom_range(0, 12)) - 6);
      mem_dy[128 + s]   = 12'(int'($urandom_range(0, 12)) - 6);
      mem_last[128 + s] = (s == l2);
      if ($urandom_range(0, 3) == 0) begin
        mem_dx[192 + s] = 12'(int'($urandom_range(0, 8)) - 4);
        mem_dy[192 + s] = 12'(int'($urandom_range(0, 8)) - 4);
      end else begin
        mem_dx[192 + s] = '0;
        mem_dy[192 + s] = '0;
      end
      mem_last[192 + s] = 1'b0;
    end
  endtask

  task automatic check_all_zero(input int cyc);
    chk("rst_pulse_x", cyc, 32'(pulse_x), 0);
    chk("rst_pulse_y", cyc, 32'(pulse_y), 0);
    chk("rst_dir_x", cyc, 32'(dir_x), 0);
    chk("rst_dir_y", cyc, 32'(dir_y), 0);
    chk("rst_done", cyc, 32'(shape_done), 0);
    chk("rst_busy", cyc, 32'(busy), 0);
    chk("rst_rom_addr", cyc, 32'(rom_addr), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_dx[i] = '0; mem_dy[i] = '0; mem_last[i] = 1'b0;
    end
    reset = 1'b1; enable = 1'b0; shape_sel = '0; period = '0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check_all_zero(0);
    @(posedge sysclk); #1 reset = 1'b0;

    // Single segment (4,2), last, period 3: one full segment then stop.
    mem_dx[0] = 12'sd4; mem_dy[0] = 12'sd2; mem_last[0] = 1'b1;
    sched(15, 0, 3, 1'b0);
    do_run(15);
    chk("segA_x_count", 15, cnt_x, 4);
    chk("segA_y_count", 15, cnt_y, 2);
    chk("segA_done_count", 15, cnt_done, 1);

    // Reset held for 3 cycles while a negative segment is running.
    mem_dx[0] = -12'sd4; mem_dy[0] = -12'sd2;
    @(posedge sysclk); #1 enable = 1'b1; shape_sel = 2'd0; period = 16'd3;
    repeat (6) @(posedge sysclk);
    @(negedge sysclk);
    chk("pre_reset_busy", 6, 32'(busy), 1);
    chk("pre_reset_dir_x", 6, 32'(dir_x), 1);
    @(posedge sysclk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      check_all_zero(100 + i);
    end
    @(posedge sysclk); #1 reset = 1'b0; enable = 1'b0;
    @(posedge sysclk);

    // Negative, zero and clamped-period segments with a mid-loop shape switch.
    mem_dx[64] = -12'sd3; mem_dy[64] = -12'sd5; mem_last[64] = 1'b0;
    mem_dx[65] = 12'sd0;  mem_dy[65] = 12'sd0;  mem_last[65] = 1'b0;
    mem_dx[66] = 12'sd2;  mem_dy[66] = 12'sd0;  mem_last[66] = 1'b1;
    fill_random();
    sched(60, 1, 0, 1'b0);
    for (int c = 20; c <= 62; c++) sel_at[c] = 2;
    do_run(60);

    // Randomised runs, dropping enable at arbitrary points.
    for (int r = 0; r < 6; r++) begin
      int e;
      fill_random();
      e = $urandom_range(300, 1500);
      sched(e, $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
      do_run(e);
    end

    // Shape without a last marker wraps after segment 63.
    fill_random();
    sched(1500, 3, 0, 1'b0);
    do_run(1500);

    // Most negative dx saturates to 2047 steps.
    mem_dx[0] = -12'sd2048; mem_dy[0] = 12'sd3; mem_last[0] = 1'b1;
    sched(4097, 0, 1, 1'b0);
    do_run(4097);
    chk("sat_x_count", 4097, cnt_x, 2047);
    chk("sat_y_count", 4097, cnt_y, 3);
    chk("sat_done_count", 4097, cnt_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
